sha256_msg_sched: RTL and testbench



---
 rtl/sha256_pkg.sv | 28 ++
 rtl/sha256_small_sigma.sv | 16 +
 rtl/sha256_msg_sched.sv | 118 +++++++++++
 tb/tb_sha256_msg_sched.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, state type and rotate helper.
// Imported by sha256_small_sigma and sha256_msg_sched.
package sha256_pkg;

   localparam int WORD_W      = 32;
   localparam int BLOCK_WORDS = 16;
   localparam int MAX_W       = 64;

   localparam int unsigned S0_R1 = 7;
   localparam int unsigned S0_R2 = 18;
   localparam int unsigned S0_SH = 3;
   localparam int unsigned S1_R1 = 17;
   localparam int unsigned S1_R2 = 19;
   localparam int unsigned S1_SH = 10;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   function automatic logic [WORD_W-1:0] rotr(
      input logic [WORD_W-1:0] x,
      input int unsigned       n
   );
      return (x >> n) | (x << (WORD_W - n));
   endfunction

endpackage

// File: rtl/sha256_small_sigma.sv
// SHA-256 small sigma: rotr(R1) ^ rotr(R2) ^ shr(SH).
// Ports: x (word in), y (sigma of x). Purely combinational.
module sha256_small_sigma
   import sha256_pkg::*;
#(
   parameter int unsigned R1 = S0_R1,
   parameter int unsigned R2 = S0_R2,
   parameter int unsigned SH = S0_SH
) (
   input  logic [WORD_W-1:0] x,
   output logic [WORD_W-1:0] y
);

   assign y = rotr(x, R1) ^ rotr(x, R2) ^ (x >> SH);

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule expander: loads a 512-bit block and streams
// W[0..NUM_W-1] over a valid/ready handshake.
// Ports: clk, rst_n (async low), start, block_in[511:0], w_valid,
// w_ready, w_out[31:0], w_idx[5:0], busy, done (1-cycle pulse).
// Option: define MSG_SCHED_ABORT_EN to add an abort input.
module sha256_msg_sched
   import sha256_pkg::*;
#(
   parameter int NUM_W = MAX_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [BLOCK_WORDS*WORD_W-1:0] block_in,
`ifdef MSG_SCHED_ABORT_EN
   input  logic                          abort,
`endif
   output logic                          w_valid,
   input  logic                          w_ready,
   output logic [WORD_W-1:0]             w_out,
   output logic [5:0]                    w_idx,
   output logic                          busy,
   output logic                          done
);

   localparam logic [5:0] LAST_T = 6'(NUM_W - 1);

   state_t state, state_nx;

   logic [WORD_W-1:0] win [BLOCK_WORDS];
   logic [5:0]        t;

   logic load, xfer, fin, kill;
   logic [WORD_W-1:0] s0, s1, nw;

`ifdef MSG_SCHED_ABORT_EN
   assign kill = abort & (state == RUN);
`else
   assign kill = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (kill || fin) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Control decode; abort wins over a transfer in the same cycle
   always_comb begin
      load = (state == IDLE) & start;
      xfer = (state == RUN) & w_ready & ~kill;
      fin  = xfer & (t == LAST_T);
   end

   sha256_small_sigma #(
      .R1(S0_R1), .R2(S0_R2), .SH(S0_SH)
   ) u_sigma0 (
      .x(win[1]),
      .y(s0)
   );

   sha256_small_sigma #(
      .R1(S1_R1), .R2(S1_R2), .SH(S1_SH)
   ) u_sigma1 (
      .x(win[14]),
      .y(s1)
   );

   // win[0] is W[t]; the word entering win[15] is W[t+16]
   assign nw = s1 + win[9] + s0 + win[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BLOCK_WORDS; i++) win[i] <= '0;
         t       <= '0;
         w_valid <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= fin;
         if (load) begin
            for (int i = 0; i < BLOCK_WORDS; i++)
               win[i] <= block_in[(BLOCK_WORDS-1-i)*WORD_W +: WORD_W];
            t       <= '0;
            w_valid <= 1'b1;
            busy    <= 1'b1;
         end else if (kill) begin
            t       <= '0;
            w_valid <= 1'b0;
            busy    <= 1'b0;
         end else if (xfer) begin
            for (int i = 0; i < BLOCK_WORDS-1; i++) win[i] <= win[i+1];
            win[BLOCK_WORDS-1] <= nw;
            if (fin) begin
               t       <= '0;
               w_valid <= 1'b0;
               busy    <= 1'b0;
            end else begin
               t <= t + 6'd1;
            end
         end
      end
   end

   assign w_out = win[0];
   assign w_idx = t;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched against a plain-arithmetic
// schedule model; random stalls and random blocks via $urandom.
module tb_sha256_msg_sched;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [511:0] block_in;
   logic         abort;
   logic         w_valid;
   logic         w_ready;
   logic [31:0]  w_out;
   logic [5:0]   w_idx;
   logic         busy;
   logic         done;

   int errs = 0;
   int checks = 0;

   logic [31:0] wexp [64];
   logic [31:0] got  [64];

   logic [511:0] abc_blk;
   logic [511:0] ff_blk;

   sha256_msg_sched #(.NUM_W(64)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .block_in(block_in),
`ifdef MSG_SCHED_ABORT_EN
      .abort   (abort),
`endif
      .w_valid (w_valid),
      .w_ready (w_ready),
      .w_out   (w_out),
      .w_idx   (w_idx),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Schedule recurrence written directly from the SHA-256 definition
   function automatic void expand(input logic [511:0] b);
      for (int i = 0; i < 16; i++) wexp[i] = b[511-32*i -: 32];
      for (int i = 16; i < 64; i++)
         wexp[i] = (rr(wexp[i-2], 17) ^ rr(wexp[i-2], 19) ^ (wexp[i-2] >> 10))
                 + wexp[i-7]
                 + (rr(wexp[i-15], 7) ^ rr(wexp[i-15], 18) ^ (wexp[i-15] >> 3))
                 + wexp[i-16];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [511:0] blk);
      start = 1'b1;
      block_in = blk;
      tick();
      start = 1'b0;
   endtask

   // mode 0: plain, 1: start pulse at t=20, 2: reset at t=30, 3: abort at t=10
   task automatic stream(input bit rnd, input int mode);
      int t = 0;
      int guard = 0;
      int lowrun = 0;
      bit quit = 0;
      while (t < 64 && guard < 2000 && !quit) begin
         chk("valid", {31'd0, w_valid}, 32'd1);
         chk("idx", {26'd0, w_idx}, t);
         chk("word", w_out, wexp[t]);
         chk("done_low", {31'd0, done}, 32'd0);
         if (mode == 2 && t == 30) begin
            rst_n = 1'b0;
            #1;
            chk("rst_valid", {31'd0, w_valid}, 32'd0);
            chk("rst_wout", w_out, 32'd0);
            chk("rst_idx", {26'd0, w_idx}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            #2 rst_n = 1'b1;
            tick();
            chk("rst_nodone", {31'd0, done}, 32'd0);
            quit = 1;
         end else begin
            if (rnd && lowrun < 5 && $urandom_range(0, 2) == 0) begin
               w_ready = 1'b0;
               lowrun++;
            end else begin
               w_ready = 1'b1;
               lowrun = 0;
            end
            start = (mode == 1 && t == 20);
            if (start) block_in = ff_blk;
            abort = (mode == 3 && t == 10);
            if (abort) w_ready = 1'b1;
            if (w_ready) got[t] = w_out;
            tick();
            start = 1'b0;
            if (abort) begin
               abort = 1'b0;
`ifdef MSG_SCHED_ABORT_EN
               chk("abort_valid", {31'd0, w_valid}, 32'd0);
               chk("abort_idx", {26'd0, w_idx}, 32'd0);
               chk("abort_done", {31'd0, done}, 32'd0);
               tick();
               chk("abort_done2", {31'd0, done}, 32'd0);
               quit = 1;
`endif
            end
            if (!quit && w_ready) t++;
            guard++;
         end
      end
      w_ready = 1'b0;
      if (!quit) begin
         chk("xfers", t, 32'd64);
         chk("end_done", {31'd0, done}, 32'd1);
         chk("end_valid", {31'd0, w_valid}, 32'd0);
         chk("end_idx", {26'd0, w_idx}, 32'd0);
         chk("end_busy", {31'd0, busy}, 32'd0);
      end
   endtask

   initial begin
      logic [511:0] rb;
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      w_ready = 1'b0;
      block_in = '0;
      abc_blk = '0;
      abc_blk[511:480] = 32'h61626380;
      abc_blk[31:0] = 32'h00000018;
      ff_blk = '1;
      #12;
      chk("reset_valid", {31'd0, w_valid}, 32'd0);
      chk("reset_wout", w_out, 32'd0);
      chk("reset_idx", {26'd0, w_idx}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      #10 rst_n = 1'b1;
      tick();

      // abc block, full throughput
      expand(abc_blk);
      load(abc_blk);
      chk("busy_run", {31'd0, busy}, 32'd1);
      stream(1'b0, 0);
      chk("abc_w16", got[16], 32'h61626380);
      chk("abc_w17", got[17], 32'h000F0000);
      chk("abc_w63", got[63], 32'h12B1EDEB);
      tick();
      chk("done_once", {31'd0, done}, 32'd0);

      // random stalls, with ignored start mid-stream
      load(abc_blk);
      stream(1'b1, 1);

      // start in the done cycle with the all-ones block
      expand(ff_blk);
      load(ff_blk);
      chk("b2b_valid", {31'd0, w_valid}, 32'd1);
      chk("b2b_w0", w_out, 32'hFFFFFFFF);
      chk("b2b_done", {31'd0, done}, 32'd0);
      stream(1'b1, 0);

      // reset mid-stream, then restart
      expand(abc_blk);
      load(abc_blk);
      stream(1'b0, 2);
      load(abc_blk);
      stream(1'b1, 0);

`ifdef MSG_SCHED_ABORT_EN
      load(abc_blk);
      stream(1'b0, 3);
      load(abc_blk);
      stream(1'b0, 0);
`endif

      // random blocks
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 16; i++) rb[511-32*i -: 32] = $urandom;
         expand(rb);
         tick();
         load(rb);
         stream(1'b1, 0);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
